// File: rtl/serial_binary_adder_if.sv
// serial_binary_adder_if: operand/result bundle with start/busy/done handshake.
interface serial_binary_adder_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Carryout;
    modport master (output start, a, b, Cin, input busy, done, S, Carryout);
    modport slave  (input start, a, b, Cin, output busy, done, S, Carryout);
endinterface

// File: rtl/serial_binary_adder.sv
// serial_binary_adder: bit-serial a+b+Cin, LSB first, one full-adder cell and a carry flop.
module serial_binary_adder #(
    parameter int WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    serial_binary_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_s_q, sh_s_d, s_q, s_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             sum_bit, carry_nxt, last;
    logic [WIDTH:0]   s_next;

    always_comb begin
        sum_bit   = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
        carry_nxt = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & carry_q) | (sh_b_q[0] & carry_q);
        s_next    = {sum_bit, sh_s_q};
        last      = cnt_q == CNT_W'(WIDTH - 1);
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        sh_s_d    = sh_s_q;
        carry_d   = carry_q;
        s_d       = s_q;
        cout_d    = cout_q;
        if (state_q == BUSY) begin
            sh_a_d  = sh_a_q >> 1;
            sh_b_d  = sh_b_q >> 1;
            sh_s_d  = s_next[WIDTH:1];
            carry_d = carry_nxt;
            cnt_d   = cnt_q + CNT_W'(1);
            // Result registers load on the final bit so they are valid alongside done.
            if (last) begin
                state_d = DONE;
                s_d     = s_next[WIDTH:1];
                cout_d  = carry_nxt;
            end
        end else begin
            state_d = bus.start ? BUSY : IDLE;
            if (bus.start) begin
                sh_a_d  = bus.a;
                sh_b_d  = bus.b;
                carry_d = bus.Cin;
                cnt_d   = '0;
                sh_s_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sh_s_q  <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            sh_s_q  <= sh_s_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy     = state_q == BUSY;
    assign bus.done     = state_q == DONE;
    assign bus.S        = s_q;
    assign bus.Carryout = cout_q;
endmodule
